addsub_multicycle: RTL and testbench

ADDSUB_MULTICYCLE -- requirements
Module: addsub_multicycle

---
 rtl/addsub_multicycle_if.sv | 28 ++
 rtl/addsub_multicycle.sv | 102 ++++++++++
 tb/tb_addsub_multicycle.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_multicycle_if.sv
// Request/response bundle for addsub_multicycle.
//   master : request source and result consumer (drives valid_i, op_i, M_i, N_i, ready_i)
//   slave  : the add/sub engine (drives ready_o, valid_o, result_o, overflow_o, zero_o)
// result_o[WIDTH] is carry-out for add, borrow for subtract.
interface addsub_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             valid_i;
  logic             ready_o;
  logic             op_i;
  logic [WIDTH-1:0] M_i;
  logic [WIDTH-1:0] N_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH:0]   result_o;
  logic             overflow_o;
  logic             zero_o;

  modport master (
    output valid_i, op_i, M_i, N_i, ready_i,
    input  ready_o, valid_o, result_o, overflow_o, zero_o
  );

  modport slave (
    input  valid_i, op_i, M_i, N_i, ready_i,
    output ready_o, valid_o, result_o, overflow_o, zero_o
  );
endinterface

// File: rtl/addsub_multicycle.sv
// Multi-cycle ripple adder/subtractor: processes CHUNK bits per clock,
// WIDTH/CHUNK cycles per operation, valid/ready handshake on both sides.
//   clk_i  : rising-edge clock
//   rst_ni : synchronous active-low reset
//   bus    : addsub_multicycle_if.slave (request in, result out)
module addsub_multicycle #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  addsub_multicycle_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("addsub_multicycle: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] n_q;     // already inverted for subtract
  logic [WIDTH-1:0] acc_q;   // working sum, chunks fill in LSB first
  logic [WIDTH-1:0] res_q;   // last completed result, only updated on completion
  logic [IW-1:0]    idx_q;
  logic             op_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   sum_c;
  logic             msb_cin;
  logic             last_c;
  logic [WIDTH-1:0] acc_next;
  int               base;

  always_comb begin
    base     = int'(idx_q) * CHUNK;
    a_c      = m_q[base +: CHUNK];
    b_c      = n_q[base +: CHUNK];
    sum_c    = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    // carry into the chunk MSB recovered from the MSB sum bit
    msb_cin  = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1];
    last_c   = (idx_q == IW'(NCHUNK - 1));
    acc_next = acc_q;
    acc_next[base +: CHUNK] = sum_c[CHUNK-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.valid_i) begin
          m_q     <= bus.M_i;
          n_q     <= bus.op_i ? ~bus.N_i : bus.N_i;
          op_q    <= bus.op_i;
          carry_q <= bus.op_i;  // +1 completes the two's-complement negate
          idx_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q   <= acc_next;
          carry_q <= sum_c[CHUNK];
          idx_q   <= idx_q + 1'b1;
          if (last_c) begin
            state_q <= DONE;
            idx_q   <= '0;
            res_q   <= acc_next;
            cout_q  <= sum_c[CHUNK] ^ op_q;  // subtract: borrow = !carry
            ovf_q   <= msb_cin ^ sum_c[CHUNK];
            zero_q  <= (acc_next == '0);
          end
        end
        DONE: if (bus.ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_o    = (state_q == IDLE) && rst_ni;
  assign bus.valid_o    = (state_q == DONE);
  assign bus.result_o   = {cout_q, res_q};
  assign bus.overflow_o = ovf_q;
  assign bus.zero_o     = zero_q;
endmodule

// File: tb/tb_addsub_multicycle.sv
module tb_addsub_multicycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_multicycle_if #(.WIDTH(16)) b16();
  addsub_multicycle_if #(.WIDTH(8))  b8();
  addsub_multicycle_if #(.WIDTH(32)) b32();

  addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16));
  addsub_multicycle #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(b8));
  addsub_multicycle #(.WIDTH(32), .CHUNK(1)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct packed {
    logic [32:0] res;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    string       name;
    bit          op;
    logic [15:0] m;
    logic [15:0] n;
    logic [16:0] res;
    bit          ovf;
    bit          zero;
  } vec_t;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(int w, bit op, longint unsigned m, longint unsigned n);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned r;
    bit c, sa, sb, sr;
    exp_t e;
    m = m & mask;
    n = n & mask;
    if (op) begin
      r = (m - n) & mask;
      c = (m < n);
    end else begin
      r = (m + n) & mask;
      c = ((m + n) >> w) != 0;
    end
    sa = ((m >> (w - 1)) & 1) != 0;
    sb = ((n >> (w - 1)) & 1) != 0;
    sr = ((r >> (w - 1)) & 1) != 0;
    e.ovf  = op ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    e.zero = (r == 0);
    e.res  = 33'(({63'd0, c} << w) | r);
    return e;
  endfunction

  task automatic drive(int w, bit v, bit op, logic [31:0] m, logic [31:0] n, bit rdy);
    case (w)
      0: begin b16.valid_i = v; b16.op_i = op; b16.M_i = m[15:0]; b16.N_i = n[15:0]; b16.ready_i = rdy; end
      1: begin b8.valid_i  = v; b8.op_i  = op; b8.M_i  = m[7:0];  b8.N_i  = n[7:0];  b8.ready_i  = rdy; end
      default: begin b32.valid_i = v; b32.op_i = op; b32.M_i = m; b32.N_i = n; b32.ready_i = rdy; end
    endcase
  endtask

  task automatic sample(int w, output logic vo, output logic ro, output logic [32:0] r,
                        output logic ov, output logic z);
    case (w)
      0: begin vo = b16.valid_o; ro = b16.ready_o; r = {16'd0, b16.result_o}; ov = b16.overflow_o; z = b16.zero_o; end
      1: begin vo = b8.valid_o;  ro = b8.ready_o;  r = {24'd0, b8.result_o};  ov = b8.overflow_o;  z = b8.zero_o;  end
      default: begin vo = b32.valid_o; ro = b32.ready_o; r = b32.result_o; ov = b32.overflow_o; z = b32.zero_o; end
    endcase
  endtask

  task automatic churn(int w, bit rdy);
    drive(w, 1'($urandom), 1'($urandom), $urandom, $urandom, rdy);
  endtask

  // One full transaction; inputs churn randomly after accept.
  task automatic do_op(int w, bit op, logic [31:0] m, logic [31:0] n, int hold,
                       output logic [32:0] res, output logic ovf, output logic zero,
                       output int lat, output bit stable, output bit post_ok);
    logic vo, ro, ov, z;
    logic [32:0] r;
    int k;
    k = 0;
    sample(w, vo, ro, r, ov, z);
    while (!ro && k < 40) begin
      @(posedge clk); #1; k++;
      sample(w, vo, ro, r, ov, z);
    end
    drive(w, 1'b1, op, m, n, 1'b0);
    @(posedge clk); #1;
    lat = 0;
    sample(w, vo, ro, r, ov, z);
    while (!vo && lat < 64) begin
      churn(w, 1'b0);
      @(posedge clk); #1; lat++;
      sample(w, vo, ro, r, ov, z);
    end
    res = r; ovf = ov; zero = z;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      churn(w, 1'b0);
      @(posedge clk); #1;
      sample(w, vo, ro, r, ov, z);
      if (!vo || ro || r !== res || ov !== ovf || z !== zero) stable = 1'b0;
    end
    churn(w, 1'b1);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, '0, '0, 1'b0);
    sample(w, vo, ro, r, ov, z);
    post_ok = !vo && ro;
  endtask

  vec_t vecs[8];

  initial begin
    logic vo, ro, ov, z;
    logic [32:0] r, res;
    logic ovf, zero;
    int lat, cnt, wd;
    bit stable, post_ok;
    exp_t e;
    logic [31:0] m, n, mask;
    bit op;
    logic [31:0] corner[4];

    vecs[0] = '{"sub_1234_0234", 1'b1, 16'h1234, 16'h0234, 17'h01000, 1'b0, 1'b0};
    vecs[1] = '{"sub_borrow",    1'b1, 16'h0001, 16'h0002, 17'h1FFFF, 1'b0, 1'b0};
    vecs[2] = '{"add_wrap_zero", 1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0, 1'b1};
    vecs[3] = '{"add_ovf",       1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1, 1'b0};
    vecs[4] = '{"sub_eq_zero",   1'b1, 16'h0005, 16'h0005, 17'h00000, 1'b0, 1'b1};
    vecs[5] = '{"add_neg_ovf",   1'b0, 16'h8000, 16'h8000, 17'h10000, 1'b1, 1'b1};
    vecs[6] = '{"sub_0_min",     1'b1, 16'h0000, 16'h8000, 17'h18000, 1'b1, 1'b0};
    vecs[7] = '{"add_plain",     1'b0, 16'h1234, 16'h4321, 17'h05555, 1'b0, 1'b0};

    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, '0, '0, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    sample(0, vo, ro, r, ov, z);
    check("rst_ready", {63'd0, ro}, 64'd0);
    check("rst_outputs", {29'd0, r, vo, ov, z}, 64'd0);
    rst_n = 1'b1;
    #1;
    sample(0, vo, ro, r, ov, z);
    check("rst_release_ready", {63'd0, ro}, 64'd1);

    // directed table
    foreach (vecs[i]) begin
      do_op(0, vecs[i].op, {16'd0, vecs[i].m}, {16'd0, vecs[i].n}, 0, res, ovf, zero, lat, stable, post_ok);
      check({vecs[i].name, "_lat"}, 64'(lat), 64'd4);
      check({vecs[i].name, "_res"}, 64'(res), 64'(vecs[i].res));
      check({vecs[i].name, "_ovf_zero"}, {62'd0, ovf, zero}, {62'd0, vecs[i].ovf, vecs[i].zero});
      check({vecs[i].name, "_handoff"}, {63'd0, post_ok}, 64'd1);
    end

    // backpressure
    do_op(0, 1'b1, 32'h8000, 32'h0001, 5, res, ovf, zero, lat, stable, post_ok);
    check("bp_res", 64'(res), 64'h07FFF);
    check("bp_ovf", {63'd0, ovf}, 64'd1);
    check("bp_stable", {63'd0, stable}, 64'd1);
    check("bp_release", {63'd0, post_ok}, 64'd1);

    // reset during the second CALC cycle
    drive(0, 1'b1, 1'b0, 32'h1111, 32'h2222, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    sample(0, vo, ro, r, ov, z);
    check("midrst_valid_ready", {62'd0, vo, ro}, 64'd0);
    check("midrst_result", 64'(r), 64'd0);
    rst_n = 1'b1;
    #1;
    sample(0, vo, ro, r, ov, z);
    check("midrst_release_ready", {63'd0, ro}, 64'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sample(0, vo, ro, r, ov, z);
      if (vo) cnt++;
    end
    check("midrst_no_pulse", 64'(cnt), 64'd0);
    do_op(0, 1'b0, 32'h1111, 32'h2222, 0, res, ovf, zero, lat, stable, post_ok);
    check("midrst_next_op", {29'd0, res, ovf, zero, 2'(lat)}, {29'd0, 33'h03333, 1'b0, 1'b0, 2'(4)});

    // random sweeps on all three configurations
    for (int w = 0; w < 3; w++) begin
      wd   = (w == 0) ? 16 : (w == 1) ? 8 : 32;
      mask = (w == 2) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 1);
      corner[0] = 32'd0;
      corner[1] = mask;
      corner[2] = 32'd1 << (wd - 1);
      corner[3] = mask >> 1;
      for (int t = 0; t < ((w == 2) ? 20 : 30); t++) begin
        op = 1'($urandom);
        m  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : ($urandom & mask);
        n  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : ($urandom & mask);
        e  = model(wd, op, 64'(m), 64'(n));
        do_op(w, op, m, n, $urandom_range(0, 2), res, ovf, zero, lat, stable, post_ok);
        check($sformatf("rand_w%0d_op%0d_%0h_%0h", wd, op, m, n),
              {29'd0, res, ovf, zero}, {29'd0, e.res, e.ovf, e.zero});
        check($sformatf("rand_w%0d_lat_hs", wd), {31'd0, lat, stable, post_ok},
              {31'd0, wd / ((w == 0) ? 4 : (w == 1) ? 8 : 1), 1'b1, 1'b1});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
